// File: rtl/dma_controller_mc.sv
// dma_controller_mc: multi-channel round-robin DMA that bursts each channel's buffer into memory one line per write handshake.
module dma_controller_mc #(
  parameter int WORD_SIZE  = 16,
  parameter int LINE_WORDS = 4,
  parameter int NUM_CH     = 2,
  parameter int LEN_W      = 4,
  localparam int CW        = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_CH-1:0]           cmd_valid,
  input  logic [NUM_CH*WORD_SIZE-1:0] cmd_addr,
  input  logic [NUM_CH*LEN_W-1:0]     cmd_len,
  output logic [NUM_CH-1:0]           cmd_ack,
  output logic                        br,
  input  logic                        bg,
  output logic                        mem_write,
  output logic [WORD_SIZE-1:0]        mem_addr,
  input  logic                        write_ack,
  output logic [CW-1:0]               dev_ch,
  output logic [WORD_SIZE-1:0]        dev_offset,
  output logic                        busy,
  output logic [NUM_CH-1:0]           done
);
  typedef enum logic [2:0] {IDLE, ZCHK, REQ, XFER, DONE} state_t;
  state_t st_q, st_d;
  logic [NUM_CH-1:0] pend_q, pend_d, ack1_q, cmd_ack_q, done_q, done_d, lat, rot;
  logic [NUM_CH-1:0][WORD_SIZE-1:0] addr_q;
  logic [NUM_CH-1:0][LEN_W-1:0] len_q;
  logic [CW-1:0] rr_q, rr_d, win_q, win_d, pick, off, nxt;
  logic [CW:0] sum;
  logic [LEN_W-1:0] line_q, line_d;
  logic any, xfer, zero_len;
  assign lat = cmd_valid & ~pend_q;
  assign xfer = st_q == XFER;
  assign zero_len = len_q[win_q] == '0;
  assign nxt = win_q == CW'(NUM_CH - 1) ? '0 : win_q + 1'b1;
  // Rotate pending so the lowest set bit is the first channel at or after rr_q.
  always_comb begin
    rot = NUM_CH'({pend_q, pend_q} >> rr_q);
    any = |pend_q;
    off = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) off = rot[i] ? CW'(i) : off;
    sum = {1'b0, rr_q} + {1'b0, off};
    pick = sum >= (CW+1)'(NUM_CH) ? CW'(sum - (CW+1)'(NUM_CH)) : CW'(sum);
  end
  always_comb begin
    st_d = st_q;
    win_d = win_q;
    line_d = line_q;
    rr_d = rr_q;
    done_d = '0;
    pend_d = pend_q | lat;
    case (st_q)
      IDLE: if (any) begin
        win_d = pick;
        line_d = '0;
        st_d = ZCHK;
      end
      ZCHK: if (zero_len) begin
        done_d[win_q] = 1'b1;
        pend_d[win_q] = 1'b0;
        rr_d = nxt;
        st_d = IDLE;
      end else st_d = REQ;
      REQ: st_d = bg ? XFER : REQ;
      XFER: if (write_ack) begin
        line_d = line_q + 1'b1;
        if (line_d == len_q[win_q]) begin
          done_d[win_q] = 1'b1;
          pend_d[win_q] = 1'b0;
          rr_d = nxt;
          st_d = DONE;
        end else st_d = bg ? XFER : REQ;
      end else st_d = bg ? XFER : REQ;
      DONE: st_d = bg ? DONE : IDLE;
      default: st_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      st_q <= IDLE;
      pend_q <= '0;
      ack1_q <= '0;
      cmd_ack_q <= '0;
      done_q <= '0;
      rr_q <= '0;
      win_q <= '0;
      line_q <= '0;
      addr_q <= '0;
      len_q <= '0;
    end else begin
      st_q <= st_d;
      pend_q <= pend_d;
      ack1_q <= lat;
      cmd_ack_q <= ack1_q;
      done_q <= done_d;
      rr_q <= rr_d;
      win_q <= win_d;
      line_q <= line_d;
      for (int c = 0; c < NUM_CH; c++)
        if (lat[c]) begin
          addr_q[c] <= cmd_addr[c*WORD_SIZE +: WORD_SIZE];
          len_q[c] <= cmd_len[c*LEN_W +: LEN_W];
        end
    end
  end
  // cmd_ack is delayed one extra cycle so it lines up with br for a fresh command.
  assign cmd_ack = cmd_ack_q;
  assign done = done_q;
  assign busy = st_q != IDLE;
  assign br = st_q == REQ || xfer || (st_q == ZCHK && !zero_len);
  assign mem_write = xfer;
  assign dev_ch = xfer ? win_q : '0;
  assign dev_offset = xfer ? WORD_SIZE'(line_q) * WORD_SIZE'(LINE_WORDS) : '0;
  assign mem_addr = xfer ? addr_q[win_q] + dev_offset : '0;
endmodule

// File: tb/tb_dma_controller_mc.sv
// tb_dma_controller_mc: directed checks of dma_controller_mc with a bus/memory responder model.
module tb_dma_controller_mc;
  logic        clk = 1'b0, reset_n;
  logic [1:0]  cmd_valid, cmd_ack, done;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic        br, bg, mem_write, write_ack, busy;
  logic [15:0] mem_addr, dev_offset;
  logic [0:0]  dev_ch;
  int n_vec = 0, n_mis = 0;
  int iss_a[$], iss_o[$], iss_c[$], dq[$];
  int wc = 0, hold = 0, acks = 0;
  logic bq = 1'b0, br_seen = 1'b0, reclaim = 1'b0;

  dma_controller_mc dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_ack(cmd_ack), .br(br), .bg(bg), .mem_write(mem_write),
    .mem_addr(mem_addr), .write_ack(write_ack), .dev_ch(dev_ch),
    .dev_offset(dev_offset), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clr();
    iss_a.delete(); iss_o.delete(); iss_c.delete(); dq.delete();
    acks = 0;
    br_seen = 1'b0;
  endtask

  task automatic send(input logic [1:0] m);
    int n = 0;
    cmd_valid = m;
    do begin tick(); n++; end while (cmd_ack == 2'b00 && n < 10);
    chk("ack", {30'd0, cmd_ack}, {30'd0, m});
    cmd_valid = 2'b00;
  endtask

  task automatic wait_dn(input int target, input int lim);
    int n = 0;
    do begin tick(); n++; end while (!(dq.size() >= target && !busy) && n < lim);
    chk("done_count", dq.size(), target);
    chk("idle_after", busy, 0);
  endtask

  // Bus/memory responder: bg follows br one cycle later, write_ack 2 cycles into each line.
  initial begin
    bg = 1'b0;
    write_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      write_ack = 1'b0;
      if (br) br_seen = 1'b1;
      for (int c = 0; c < 2; c++) if (done[c]) dq.push_back(c);
      if (hold > 0) begin hold--; bg = 1'b0; end else bg = bq;
      bq = br;
      wc = mem_write ? wc + 1 : 0;
      if (wc == 1) begin
        iss_a.push_back(int'(mem_addr));
        iss_o.push_back(int'(dev_offset));
        iss_c.push_back(int'(dev_ch));
        if (reclaim && dev_offset == 16'd4) begin reclaim = 1'b0; hold = 4; bg = 1'b0; end
      end
      if (wc == 3) begin write_ack = 1'b1; wc = 0; acks++; end
    end
  end

  initial begin
    int n;
    reset_n = 1'b0; cmd_valid = '0; cmd_addr = '0; cmd_len = '0;
    repeat (2) tick();
    chk("rst_br", br, 0);
    chk("rst_mw", mem_write, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ack", cmd_ack, 0);
    chk("rst_addr", mem_addr, 0);
    reset_n = 1'b1;
    tick();
    // Single transfer plus latency
    clr();
    cmd_addr[15:0] = 16'h01F4; cmd_len[3:0] = 4'd3;
    cmd_valid = 2'b01;
    tick();
    chk("lat_ack_c1", cmd_ack, 0);
    chk("lat_br_c1", br, 0);
    tick();
    chk("lat_ack_c2", cmd_ack, 2'b01);
    chk("lat_br_c2", br, 1);
    cmd_valid = 2'b00;
    wait_dn(1, 200);
    chk("sgl_n", iss_a.size(), 3);
    chk("sgl_a0", iss_a[0], 32'h01F4);
    chk("sgl_a1", iss_a[1], 32'h01F8);
    chk("sgl_a2", iss_a[2], 32'h01FC);
    chk("sgl_o1", iss_o[1], 4);
    chk("sgl_o2", iss_o[2], 8);
    chk("sgl_ch", dq[0], 0);
    chk("sgl_br_low", br, 0);
    // Zero length on ch1
    clr();
    cmd_len[7:4] = 4'd0;
    send(2'b10);
    wait_dn(1, 50);
    chk("zl_ch", dq[0], 1);
    chk("zl_no_br", br_seen, 0);
    // Simultaneous pair from rr=0
    clr();
    cmd_addr = {16'h2000, 16'h1000}; cmd_len = {4'd1, 4'd1};
    send(2'b11);
    wait_dn(2, 300);
    chk("arb1_first", dq[0], 0);
    chk("arb1_second", dq[1], 1);
    chk("arb1_a0", iss_a[0], 32'h1000);
    chk("arb1_a1", iss_a[1], 32'h2000);
    // Zero-length ch0 moves rr to 1, so the next pair starts at ch1
    clr();
    cmd_len[3:0] = 4'd0;
    send(2'b01);
    wait_dn(1, 50);
    clr();
    cmd_len = {4'd1, 4'd1};
    send(2'b11);
    wait_dn(2, 300);
    chk("arb2_first", dq[0], 1);
    chk("arb2_second", dq[1], 0);
    chk("arb2_a0", iss_a[0], 32'h2000);
    // CPU reclaim mid line 1
    clr();
    cmd_addr[15:0] = 16'h0100; cmd_len[3:0] = 4'd2;
    reclaim = 1'b1;
    send(2'b01);
    wait_dn(1, 300);
    chk("rcl_n", iss_a.size(), 3);
    chk("rcl_a1", iss_a[1], 32'h0104);
    chk("rcl_a2", iss_a[2], 32'h0104);
    chk("rcl_acks", acks, 2);
    // Address wrap on ch1
    clr();
    cmd_addr[31:16] = 16'hFFFC; cmd_len[7:4] = 4'd2;
    send(2'b10);
    wait_dn(1, 200);
    chk("wrap_n", iss_a.size(), 2);
    chk("wrap_a0", iss_a[0], 32'hFFFC);
    chk("wrap_a1", iss_a[1], 32'h0000);
    chk("wrap_ch", iss_c[0], 1);
    // Reset during XFER
    clr();
    cmd_addr[15:0] = 16'h0200; cmd_len[3:0] = 4'd3;
    send(2'b01);
    n = 0;
    while (!mem_write && n < 20) begin tick(); n++; end
    chk("rx_in_xfer", mem_write, 1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("rx_br", br, 0);
    chk("rx_mw", mem_write, 0);
    chk("rx_busy", busy, 0);
    chk("rx_done", done, 0);
    repeat (5) tick();
    chk("rx_not_pending", busy, 0);
    chk("rx_no_done", dq.size(), 0);
    clr();
    cmd_addr[15:0] = 16'h0300; cmd_len[3:0] = 4'd1;
    send(2'b01);
    wait_dn(1, 100);
    chk("rx_fresh_a", iss_a[0], 32'h0300);
    chk("rx_fresh_ch", dq[0], 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule

// File: doc/dma_controller_mc.md
Name: dma_controller_mc

Overview:
Parametrised multi-channel successor to the single-channel DMA controller on the CPU/Memory bus. It accepts transfer commands from up to NUM_CH external devices and arbitrates between them round-robin. For each transfer it requests the bus from the CPU with br/bg. It then moves each channel's buffer into memory as line-sized bursts, giving each line one memory write handshake. It raises a per-channel completion interrupt when a transfer finishes. It sits between the external devices, the CPU bus-grant logic and memory port 2.

Parameters:
WORD_SIZE, 16, bits per word; address width.
LINE_WORDS, 4, words per memory line; one burst equals one line, so the data bus is WORD_SIZE*LINE_WORDS wide.
NUM_CH, 2, number of DMA channels (1..8).
LEN_W, 4, width of the per-channel length field, counted in lines.

Ports:
clk  in  1  clock
reset_n  in  1  synchronous active-low reset
cmd_valid  in  NUM_CH  per-channel command request, level
cmd_addr  in  NUM_CH*WORD_SIZE  per-channel destination base address; channel c uses slice [c*WORD_SIZE +: WORD_SIZE]
cmd_len  in  NUM_CH*LEN_W  per-channel transfer length in lines
cmd_ack  out  NUM_CH  one-cycle pulse: command latched
br  out  1  bus request to CPU
bg  in  1  bus grant from CPU
mem_write  out  1  memory write request (port 2)
mem_addr  out  WORD_SIZE  memory address for the current line
write_ack  in  1  memory write complete, one-cycle pulse
dev_ch  out  clog2(NUM_CH) (min 1)  channel whose device drives the data bus
dev_offset  out  WORD_SIZE  word offset into the device buffer for the current line
busy  out  1  a transfer is in progress
done  out  NUM_CH  one-cycle completion interrupt per channel

Behaviour:
- Reset: clk edge with reset_n=0 forces all outputs to 0, the FSM to IDLE, the round-robin pointer to channel 0, and all latched commands to invalid. Reset mid-transfer abandons the transfer with no done pulse.
- Command latch:
  - When cmd_valid[c]=1 and channel c is not pending, latch cmd_addr[c] and cmd_len[c], mark c pending, and pulse cmd_ack[c] on the next cycle.
  - Commands for several channels can latch in the same cycle.
  - cmd_valid[c] held after ack is ignored until channel c completes.
- Round-robin selection: the first pending channel at or after rr_ptr wins. After a completion, rr_ptr becomes the winner+1 mod NUM_CH.
- FSM states:
  - IDLE: if any channel is pending, select the winner and go to ZCHK.
  - ZCHK:
    - If the winner's len==0, pulse done[win] the next cycle without raising br, clear pending, and return to IDLE.
    - Otherwise set br=1 and go to REQ.
  - REQ: hold br=1. When bg=1, go to XFER.
  - XFER:
    - Drive mem_write=1 with mem_addr = base + line_idx*LINE_WORDS (mod 2^WORD_SIZE, wrap allowed) and dev_offset = line_idx*LINE_WORDS.
    - dev_ch = winner.
    - On write_ack: line_idx+1. If line_idx+1==len, go to DONE; otherwise stay in XFER with the next line, with mem_write staying high.
    - If bg falls with no write_ack: drop mem_write, keep line_idx, keep br=1, return to REQ (CPU reclaim). The interrupted line is redone in full.
    - If bg falls in the same cycle as write_ack, the ack counts.
  - DONE:
    - Drop br and mem_write, pulse done[win] for 1 cycle, clear pending, advance rr_ptr.
    - Wait until bg==0, then go to IDLE.
- busy=1 in every state except IDLE.
- Latency: br rises 2 cycles after cmd_valid, which is also the cycle cmd_ack pulses. The first mem_write rises 1 cycle after bg.
- A new command for the active channel is not accepted until its done pulse.

Test Plan:
- Single transfer:
  - Stimulus: ch0 with addr=0x01F4, len=3 lines; bg asserted 1 cycle after br; write_ack 2 cycles after each mem_write.
  - Required response: mem_addr 0x01F4, 0x01F8, 0x01FC; dev_offset 0, 4, 8; done[0] pulses once; br low afterward.
- Zero length:
  - Stimulus: ch1 with len=0.
  - Required response: cmd_ack[1], then done[1] with br never asserted.
- Arbitration:
  - Stimulus: ch0 and ch1 issue commands in the same cycle, each len=1.
  - Required response: ch0 serviced first, then ch1. A second simultaneous pair is serviced ch1 first.
- CPU reclaim:
  - Stimulus: bg dropped mid-line 1 of a len=2 transfer; bg reasserted 5 cycles later.
  - Required response: line 1 re-issued at the same mem_addr; exactly 2 write_acks counted; one done pulse.
- Address wrap:
  - Stimulus: addr=0xFFFC, len=2.
  - Required response: mem_addr 0xFFFC, then 0x0000.
- Reset mid-XFER:
  - Stimulus: reset_n=0 for 1 cycle during XFER.
  - Required response: br, mem_write, busy and done all 0; channel not pending; a fresh command afterward completes normally.
